// File: rtl/tmp101_temperature_assembler_pkg.sv
// Shared definitions for the TMP101 temperature assembler slice.
// Purpose: state encoding for the assembler FSM, register geometry constants
//          and the small arithmetic helpers shared by the parent and the
//          double-dabble converter.
// Contents:
//   state_t          - assembler FSM states (WAIT_MSB, WAIT_LSB, CONVERT)
//   TMP101_*         - raw register width, fraction width, integer width
//   frac_to_tenths() - floor(frac*10/16) for the tenths display digit
//   bcd_add3()       - double-dabble nibble correction (+3 when >= 5)
package tmp101_temperature_assembler_pkg;

  localparam int TMP101_FRAC_BITS = 4;
  localparam int TMP101_RAW_WIDTH = 12;
  localparam int TMP101_INT_BITS  = 8;

  typedef enum logic [1:0] {
    WAIT_MSB = 2'd0,
    WAIT_LSB = 2'd1,
    CONVERT  = 2'd2
  } state_t;

  // The fraction is in sixteenths of a degree; scaling by 10 and dropping
  // the four fractional bits truncates toward zero, which is what the
  // display shows.
  function automatic logic [3:0] frac_to_tenths(input logic [3:0] frac);
    logic [7:0] scaled;
    scaled = {4'd0, frac} * 8'd10;
    return scaled[7:4];
  endfunction

  function automatic logic [3:0] bcd_add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/tmp101_temperature_assembler_bin8_to_bcd3.sv
// bin8_to_bcd3: sequential double-dabble converter, one bit per clock.
// Ports:
//   clock    in  system clock
//   Reset    in  asynchronous active-high reset
//   Start    in  1-cycle load request; Bin is captured on this edge
//   Bin      in  8-bit unsigned value to convert
//   Done     out high once all iterations are complete, until the next edge
//   Hundreds out BCD hundreds digit
//   Tens     out BCD tens digit
//   Ones     out BCD ones digit
// After Start is sampled, CONVERT_BITS edges perform the add-3/shift steps;
// Done is then high for exactly one cycle with the digits stable.
module bin8_to_bcd3
  import tmp101_temperature_assembler_pkg::*;
#(
  parameter int CONVERT_BITS = 8
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] Bin,
  output logic       Done,
  output logic [3:0] Hundreds,
  output logic [3:0] Tens,
  output logic [3:0] Ones
);

  logic [7:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  count_q, count_d;
  logic        active_q, active_d;
  logic [11:0] bcd_adj;

  // Each iteration corrects every nibble first and then shifts, so the last
  // shift leaves the digits final without a trailing correction.
  always_comb begin
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    count_d  = count_q;
    active_d = active_q;
    bcd_adj  = {bcd_add3(bcd_q[11:8]), bcd_add3(bcd_q[7:4]), bcd_add3(bcd_q[3:0])};
    if (Start) begin
      bin_d    = Bin;
      bcd_d    = 12'd0;
      count_d  = 4'(CONVERT_BITS);
      active_d = 1'b1;
    end else if (active_q) begin
      if (count_q != 4'd0) begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        count_d        = count_q - 4'd1;
      end else begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

  assign Done     = active_q && (count_q == 4'd0);
  assign Hundreds = bcd_q[11:8];
  assign Tens     = bcd_q[7:4];
  assign Ones     = bcd_q[3:0];

endmodule

// File: rtl/tmp101_temperature_assembler.sv
// tmp101_temperature_assembler: turns the two received TMP101 temperature
// bytes into a 12-bit reading plus sign and BCD digits for the display.
// Ports:
//   clock        in   system clock
//   Reset        in   asynchronous active-high reset
//   FrameStart   in   pulse at I2C START; re-aligns MSB/LSB ordering
//   ByteValid    in   pulse: ReceivedData holds a complete byte
//   ReceivedData in   received byte, MSB of the register first
//   TempRaw      out  last reading {MSB, LSB[7:4]}, two's complement
//   Sign         out  1 = negative reading
//   BCDHundreds  out  integer magnitude hundreds digit
//   BCDTens      out  integer magnitude tens digit
//   BCDOnes      out  integer magnitude ones digit
//   BCDTenths    out  fractional tenths digit
//   DataReady    out  1-cycle pulse when all outputs update together
//   Busy         out  high while converting
//   Overrun      out  1-cycle pulse: a byte arrived while converting and was dropped
module tmp101_temperature_assembler
  import tmp101_temperature_assembler_pkg::*;
#(
  parameter int CONVERT_BITS = 8
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        FrameStart,
  input  logic        ByteValid,
  input  logic [7:0]  ReceivedData,
  output logic [11:0] TempRaw,
  output logic        Sign,
  output logic [3:0]  BCDHundreds,
  output logic [3:0]  BCDTens,
  output logic [3:0]  BCDOnes,
  output logic [3:0]  BCDTenths,
  output logic        DataReady,
  output logic        Busy,
  output logic        Overrun
);

  state_t state_q, state_d;
  logic [7:0]  msb_q, msb_d;
  logic [11:0] raw_pend_q, raw_pend_d;
  logic        sign_pend_q, sign_pend_d;
  logic [3:0]  tenths_pend_q, tenths_pend_d;
  logic [11:0] temp_raw_q, temp_raw_d;
  logic        sign_q, sign_d;
  logic [3:0]  hundreds_q, hundreds_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [3:0]  tenths_q, tenths_d;
  logic        data_ready_q, data_ready_d;
  logic        overrun_q, overrun_d;

  logic [11:0] raw_new;
  logic [12:0] mag;
  logic        conv_start;
  logic        conv_done;
  logic [3:0]  conv_hundreds, conv_tens, conv_ones;

  // The candidate reading is formed from the held MSB and the byte on the
  // bus; it is only used on the cycle the LSB is accepted. The magnitude is
  // 13 bits wide so that -128.0 (0x800) negates to +128 without wrapping.
  always_comb begin
    raw_new = {msb_q, ReceivedData[7:4]};
    if (raw_new[TMP101_RAW_WIDTH-1]) begin
      mag = {1'b0, ~raw_new} + 13'd1;
    end else begin
      mag = {1'b0, raw_new};
    end
  end

  // Sign, raw value and tenths are captured alongside the converter load
  // and held in the pending registers so that every output changes on the
  // same edge as the BCD digits. FrameStart with a byte re-aligns and takes
  // the byte as a fresh MSB; FrameStart while converting is ignored.
  always_comb begin
    state_d       = state_q;
    msb_d         = msb_q;
    raw_pend_d    = raw_pend_q;
    sign_pend_d   = sign_pend_q;
    tenths_pend_d = tenths_pend_q;
    temp_raw_d    = temp_raw_q;
    sign_d        = sign_q;
    hundreds_d    = hundreds_q;
    tens_d        = tens_q;
    ones_d        = ones_q;
    tenths_d      = tenths_q;
    data_ready_d  = 1'b0;
    overrun_d     = 1'b0;
    conv_start    = 1'b0;
    unique case (state_q)
      WAIT_MSB: begin
        if (ByteValid) begin
          msb_d   = ReceivedData;
          state_d = WAIT_LSB;
        end
      end
      WAIT_LSB: begin
        if (ByteValid && FrameStart) begin
          msb_d   = ReceivedData;
          state_d = WAIT_LSB;
        end else if (ByteValid) begin
          raw_pend_d    = raw_new;
          sign_pend_d   = raw_new[TMP101_RAW_WIDTH-1];
          tenths_pend_d = frac_to_tenths(mag[TMP101_FRAC_BITS-1:0]);
          conv_start    = 1'b1;
          state_d       = CONVERT;
        end else if (FrameStart) begin
          state_d = WAIT_MSB;
        end
      end
      CONVERT: begin
        overrun_d = ByteValid;
        if (conv_done) begin
          temp_raw_d   = raw_pend_q;
          sign_d       = sign_pend_q;
          tenths_d     = tenths_pend_q;
          hundreds_d   = conv_hundreds;
          tens_d       = conv_tens;
          ones_d       = conv_ones;
          data_ready_d = 1'b1;
          state_d      = WAIT_MSB;
        end
      end
      default: state_d = WAIT_MSB;
    endcase
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= WAIT_MSB;
      msb_q         <= '0;
      raw_pend_q    <= '0;
      sign_pend_q   <= 1'b0;
      tenths_pend_q <= '0;
      temp_raw_q    <= '0;
      sign_q        <= 1'b0;
      hundreds_q    <= '0;
      tens_q        <= '0;
      ones_q        <= '0;
      tenths_q      <= '0;
      data_ready_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      msb_q         <= msb_d;
      raw_pend_q    <= raw_pend_d;
      sign_pend_q   <= sign_pend_d;
      tenths_pend_q <= tenths_pend_d;
      temp_raw_q    <= temp_raw_d;
      sign_q        <= sign_d;
      hundreds_q    <= hundreds_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
      tenths_q      <= tenths_d;
      data_ready_q  <= data_ready_d;
      overrun_q     <= overrun_d;
    end
  end

  bin8_to_bcd3 #(
    .CONVERT_BITS(CONVERT_BITS)
  ) u_bcd (
    .clock    (clock),
    .Reset    (Reset),
    .Start    (conv_start),
    .Bin      (mag[TMP101_RAW_WIDTH-1:TMP101_FRAC_BITS]),
    .Done     (conv_done),
    .Hundreds (conv_hundreds),
    .Tens     (conv_tens),
    .Ones     (conv_ones)
  );

  assign TempRaw     = temp_raw_q;
  assign Sign        = sign_q;
  assign BCDHundreds = hundreds_q;
  assign BCDTens     = tens_q;
  assign BCDOnes     = ones_q;
  assign BCDTenths   = tenths_q;
  assign DataReady   = data_ready_q;
  assign Busy        = (state_q == CONVERT);
  assign Overrun     = overrun_q;

endmodule

// File: tb/tb_tmp101_temperature_assembler.sv
// Directed testbench for tmp101_temperature_assembler.
// Drives bytes on the falling edge so the DUT samples them on the next
// rising edge, and samples outputs on falling edges.
module tb_tmp101_temperature_assembler;

  logic        clock = 1'b0;
  logic        Reset;
  logic        FrameStart;
  logic        ByteValid;
  logic [7:0]  ReceivedData;
  logic [11:0] TempRaw;
  logic        Sign;
  logic [3:0]  BCDHundreds;
  logic [3:0]  BCDTens;
  logic [3:0]  BCDOnes;
  logic [3:0]  BCDTenths;
  logic        DataReady;
  logic        Busy;
  logic        Overrun;

  int testsRun = 0;
  int testsFailed = 0;

  tmp101_temperature_assembler dut (
    .clock        (clock),
    .Reset        (Reset),
    .FrameStart   (FrameStart),
    .ByteValid    (ByteValid),
    .ReceivedData (ReceivedData),
    .TempRaw      (TempRaw),
    .Sign         (Sign),
    .BCDHundreds  (BCDHundreds),
    .BCDTens      (BCDTens),
    .BCDOnes      (BCDOnes),
    .BCDTenths    (BCDTenths),
    .DataReady    (DataReady),
    .Busy         (Busy),
    .Overrun      (Overrun)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one cycle of bus activity starting at a falling edge.
  task automatic applyStimulus(input logic valid, input logic fs, input logic [7:0] data);
    ByteValid    = valid;
    FrameStart   = fs;
    ReceivedData = data;
    @(negedge clock);
    ByteValid    = 1'b0;
    FrameStart   = 1'b0;
    ReceivedData = 8'h00;
  endtask

  task automatic checkAllOutputs(input string tag, input logic [11:0] eRaw, input logic eSign,
                                 input logic [3:0] eH, input logic [3:0] eT,
                                 input logic [3:0] eO, input logic [3:0] eTn);
    checkOutput({tag, " raw"},      16'(TempRaw),     16'(eRaw));
    checkOutput({tag, " sign"},     16'(Sign),        16'(eSign));
    checkOutput({tag, " hundreds"}, 16'(BCDHundreds), 16'(eH));
    checkOutput({tag, " tens"},     16'(BCDTens),     16'(eT));
    checkOutput({tag, " ones"},     16'(BCDOnes),     16'(eO));
    checkOutput({tag, " tenths"},   16'(BCDTenths),   16'(eTn));
  endtask

  // Sends MSB then LSB and watches 12 edges after the LSB edge (E0).
  // DataReady must appear exactly after E9 and only once. A nonzero inj
  // drives a stray byte on edge E(inj+1) and expects Overrun after it.
  task automatic runConversion(input string tag, input logic [7:0] msb, input logic [7:0] lsb,
                               input logic msbWithFs, input int inj,
                               input logic [11:0] eRaw, input logic eSign,
                               input logic [3:0] eH, input logic [3:0] eT,
                               input logic [3:0] eO, input logic [3:0] eTn);
    int pulses;
    int readyAt;
    pulses  = 0;
    readyAt = -1;
    applyStimulus(1'b1, msbWithFs, msb);
    applyStimulus(1'b1, 1'b0, lsb);
    checkOutput({tag, " busy at E0"}, 16'(Busy), 16'd1);
    for (int k = 1; k <= 12; k++) begin
      if (inj != 0 && k - 1 == inj) begin
        ByteValid    = 1'b1;
        ReceivedData = 8'hAA;
      end
      @(negedge clock);
      ByteValid    = 1'b0;
      ReceivedData = 8'h00;
      if (inj != 0 && k == inj + 1) checkOutput({tag, " overrun"}, 16'(Overrun), 16'd1);
      if (k == 8) checkOutput({tag, " busy at E8"}, 16'(Busy), 16'd1);
      if (k == 9) checkOutput({tag, " busy at E9"}, 16'(Busy), 16'd0);
      if (DataReady) begin
        pulses++;
        if (readyAt < 0) readyAt = k;
      end
    end
    checkOutput({tag, " ready latency"}, 16'(readyAt), 16'd9);
    checkOutput({tag, " ready pulses"},  16'(pulses),  16'd1);
    checkAllOutputs(tag, eRaw, eSign, eH, eT, eO, eTn);
  endtask

  logic [3:0] tenthsTable [16] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4,
                                   4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd8, 4'd8, 4'd9};

  initial begin
    int pulses;
    Reset        = 1'b1;
    FrameStart   = 1'b0;
    ByteValid    = 1'b0;
    ReceivedData = 8'h00;
    repeat (2) @(negedge clock);
    checkAllOutputs("reset", 12'h000, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    checkOutput("reset ready",   16'(DataReady), 16'd0);
    checkOutput("reset busy",    16'(Busy),      16'd0);
    checkOutput("reset overrun", 16'(Overrun),   16'd0);
    Reset = 1'b0;
    @(negedge clock);

    // 25.0 C and -25.0 C
    runConversion("pos25", 8'h19, 8'h00, 1'b0, 0, 12'h190, 1'b0, 4'd0, 4'd2, 4'd5, 4'd0);
    runConversion("neg25", 8'hE7, 8'h00, 1'b0, 0, 12'hE70, 1'b1, 4'd0, 4'd2, 4'd5, 4'd0);

    // Range boundaries
    runConversion("max",   8'h7F, 8'hF0, 1'b0, 0, 12'h7FF, 1'b0, 4'd1, 4'd2, 4'd7, 4'd9);
    runConversion("min",   8'h80, 8'h00, 1'b0, 0, 12'h800, 1'b1, 4'd1, 4'd2, 4'd8, 4'd0);
    runConversion("neg1lsb", 8'hFF, 8'hF0, 1'b0, 0, 12'hFFF, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);

    // Half-degree fraction, then the full tenths sweep
    runConversion("frac5", 8'h19, 8'h80, 1'b0, 0, 12'h198, 1'b0, 4'd0, 4'd2, 4'd5, 4'd5);
    for (int f = 0; f < 16; f++) begin
      applyStimulus(1'b1, 1'b0, 8'h19);
      applyStimulus(1'b1, 1'b0, {4'(f), 4'h0});
      repeat (10) @(negedge clock);
      checkOutput($sformatf("sweep tenths f=%0d", f), 16'(BCDTenths), 16'(tenthsTable[f]));
    end

    // Aborted frame: the MSB is discarded and outputs keep the last reading
    applyStimulus(1'b1, 1'b0, 8'h19);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("abort busy",  16'(Busy),      16'd0);
    checkOutput("abort ready", 16'(DataReady), 16'd0);
    checkOutput("abort raw held", 16'(TempRaw), 16'h19F);
    runConversion("resync32", 8'h20, 8'h00, 1'b0, 0, 12'h200, 1'b0, 4'd0, 4'd3, 4'd2, 4'd0);

    // FrameStart together with a byte takes that byte as the new MSB
    applyStimulus(1'b1, 1'b0, 8'h55);
    runConversion("fsbyte", 8'h19, 8'h00, 1'b1, 0, 12'h190, 1'b0, 4'd0, 4'd2, 4'd5, 4'd0);

    // Stray byte while converting: Overrun pulse, result unaffected
    runConversion("overrun", 8'hE7, 8'h40, 1'b0, 3, 12'hE74, 1'b1, 4'd0, 4'd2, 4'd4, 4'd7);
    checkOutput("overrun cleared", 16'(Overrun), 16'd0);

    // Reset in the middle of a conversion
    applyStimulus(1'b1, 1'b0, 8'h19);
    applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (3) @(negedge clock);
    Reset = 1'b1;
    @(negedge clock);
    Reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (DataReady) pulses++;
    end
    checkOutput("midreset no ready", 16'(pulses), 16'd0);
    checkOutput("midreset busy",     16'(Busy),   16'd0);
    checkAllOutputs("midreset", 12'h000, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
